// File: rtl/control_types.sv
// Shared control encodings and sizing constants for the immediate decode stage.
package control_types;

    typedef enum logic [2:0] {
        SE20_UI  = 3'b000,
        SE12_LI  = 3'b001,
        SE12_BR  = 3'b010,
        SE05     = 3'b011,
        ZE05_CS  = 3'b100,
        RSVD_101 = 3'b101,
        SE12_ST  = 3'b110,
        SE20_JP  = 3'b111
    } imm_ctrl;

    localparam int unsigned INST_W    = 25;
    localparam int unsigned ILL_CNT_W = 8;
    localparam int unsigned DEPTH     = 2;

endpackage

// File: rtl/imm_decode_stage_if.sv
// Upstream (instruction) and downstream (formed immediate) valid/ready channels.
interface imm_decode_stage_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 32
) ();
    import control_types::*;

    logic               IN_VALID;
    logic               IN_READY;
    logic [INST_W-1:0]  IN_INST;
    imm_ctrl            IN_SEL;
    logic [TAG_W-1:0]   IN_TAG;

    logic               OUT_VALID;
    logic               OUT_READY;
    logic [XLEN-1:0]    OUT_IMM;
    logic [TAG_W-1:0]   OUT_TAG;
    logic               OUT_ILLEGAL;

    modport master (
        output IN_VALID, IN_INST, IN_SEL, IN_TAG, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_IMM, OUT_TAG, OUT_ILLEGAL
    );

    modport slave (
        input  IN_VALID, IN_INST, IN_SEL, IN_TAG, OUT_READY,
        output IN_READY, OUT_VALID, OUT_IMM, OUT_TAG, OUT_ILLEGAL
    );

endinterface

// File: rtl/imm_form_core.sv
// Combinational RISC-V immediate formation from INST[31:7] and a format select.
module imm_form_core
    import control_types::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [INST_W-1:0] i_inst,
    input  imm_ctrl           i_sel,
    output logic [XLEN-1:0]   o_imm_c,
    output logic              o_illegal_c
);

    logic [31:7] w_inst;
    logic        w_sign;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_j;
    logic [5:0]  w_shamt;

    assign w_inst = i_inst;
    assign w_sign = w_inst[31];

    // Every signed format is first built as a sign-extended 32-bit value.
    assign w_imm_u = {w_inst[31:12], 12'b0};
    assign w_imm_i = {{20{w_sign}}, w_inst[31:20]};
    assign w_imm_s = {{20{w_sign}}, w_inst[31:25], w_inst[11:7]};
    assign w_imm_b = {{19{w_sign}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
    assign w_imm_j = {{11{w_sign}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};

    // Shift amount field is one bit wider on RV64.
    assign w_shamt = (XLEN == 64) ? w_inst[25:20] : {1'b0, w_inst[24:20]};

    always_comb begin
        o_imm_c     = '0;
        o_illegal_c = 1'b0;
        case (i_sel)
            SE20_UI: o_imm_c = XLEN'($signed(w_imm_u));
            SE12_LI: o_imm_c = XLEN'($signed(w_imm_i));
            SE12_ST: o_imm_c = XLEN'($signed(w_imm_s));
            SE12_BR: o_imm_c = XLEN'($signed(w_imm_b));
            SE20_JP: o_imm_c = XLEN'($signed(w_imm_j));
            SE05:    o_imm_c = XLEN'(w_shamt);
            ZE05_CS: o_imm_c = XLEN'(w_inst[19:15]);
            default: o_illegal_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Immediate decode stage: forms the immediate at accept time and holds it in a
// 2-entry in-order buffer with registered valid/ready handshakes.
module imm_decode_stage
    import control_types::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 FLUSH,
    output logic [ILL_CNT_W-1:0] ILL_CNT,
    imm_decode_stage_if.slave    bus
);

    localparam int unsigned CNT_W = 2;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             ill;
    } entry_t;

    entry_t               r_head;
    entry_t               r_tail;
    logic [CNT_W-1:0]     r_count;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [ILL_CNT_W-1:0] r_ill_cnt;

    entry_t               w_new;
    entry_t               w_head_nxt;
    entry_t               w_tail_nxt;
    logic [CNT_W-1:0]     w_count_nxt;
    logic [ILL_CNT_W-1:0] w_ill_cnt_nxt;
    logic [XLEN-1:0]      w_form_imm;
    logic                 w_form_ill;
    logic                 w_push;
    logic                 w_pop;

    imm_form_core #(.XLEN(XLEN)) u_form (
        .i_inst      (bus.IN_INST),
        .i_sel       (bus.IN_SEL),
        .o_imm_c     (w_form_imm),
        .o_illegal_c (w_form_ill)
    );

    assign w_new  = '{imm: w_form_imm, tag: bus.IN_TAG, ill: w_form_ill};
    assign w_push = bus.IN_VALID & r_in_ready;
    assign w_pop  = r_out_valid & bus.OUT_READY;

    // Next-state for the buffer; head is always the oldest live entry.
    always_comb begin
        w_head_nxt    = r_head;
        w_tail_nxt    = r_tail;
        w_count_nxt   = r_count;
        w_ill_cnt_nxt = r_ill_cnt;
        if (FLUSH) begin
            w_count_nxt = '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == '0) w_head_nxt = w_new;
                    else               w_tail_nxt = w_new;
                    w_count_nxt = r_count + CNT_W'(1);
                end
                2'b01: begin
                    if (r_count == CNT_W'(DEPTH)) w_head_nxt = r_tail;
                    w_count_nxt = r_count - CNT_W'(1);
                end
                2'b11: begin
                    if (r_count == CNT_W'(DEPTH)) begin
                        w_head_nxt = r_tail;
                        w_tail_nxt = w_new;
                    end else begin
                        w_head_nxt = w_new;
                    end
                end
                default: ;
            endcase
            if (w_push && w_new.ill && (r_ill_cnt != '1))
                w_ill_cnt_nxt = r_ill_cnt + ILL_CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_ill_cnt   <= '0;
        end else begin
            r_head      <= w_head_nxt;
            r_tail      <= w_tail_nxt;
            r_count     <= w_count_nxt;
            r_in_ready  <= (w_count_nxt < CNT_W'(DEPTH));
            r_out_valid <= (w_count_nxt != '0);
            r_ill_cnt   <= w_ill_cnt_nxt;
        end
    end

    assign bus.IN_READY    = r_in_ready;
    assign bus.OUT_VALID   = r_out_valid;
    assign bus.OUT_IMM     = r_head.imm;
    assign bus.OUT_TAG     = r_head.tag;
    assign bus.OUT_ILLEGAL = r_head.ill;
    assign ILL_CNT         = r_ill_cnt;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage at XLEN=64: format table plus buffer,
// flush, saturation and reset sequences.
module tb_imm_decode_stage;
    import control_types::*;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned TAG_W = 32;
    localparam int unsigned NVEC  = 15;

    typedef struct {
        logic [31:0] inst;
        imm_ctrl     sel;
        logic [63:0] imm;
        logic        ill;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [7:0] ill_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_ill = 0;

    vec_t vecs [NVEC];

    imm_decode_stage_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    imm_decode_stage #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .CLK     (clk),
        .RST     (rst),
        .FLUSH   (flush),
        .ILL_CNT (ill_cnt),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] inst, input imm_ctrl sel, input logic [31:0] tag);
        bus.IN_VALID = 1'b1;
        bus.IN_INST  = inst[31:7];
        bus.IN_SEL   = sel;
        bus.IN_TAG   = tag;
    endtask

    task automatic idle();
        bus.IN_VALID = 1'b0;
        bus.IN_INST  = '0;
        bus.IN_SEL   = SE20_UI;
        bus.IN_TAG   = '0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        int acc;
        bit pend;
        bit took;
        logic [63:0] exp_imm [3];
        logic [31:0] exp_tag [3];

        vecs[0]  = '{32'hFFF00093, SE12_LI,  64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[1]  = '{32'h800000B7, SE20_UI,  64'hFFFF_FFFF_8000_0000, 1'b0};
        vecs[2]  = '{32'h02109093, SE05,     64'h0000_0000_0000_0021, 1'b0};
        vecs[3]  = '{32'h12345037, SE20_UI,  64'h0000_0000_1234_5000, 1'b0};
        vecs[4]  = '{32'h7FF00013, SE12_LI,  64'h0000_0000_0000_07FF, 1'b0};
        vecs[5]  = '{32'hFE000E23, SE12_ST,  64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
        vecs[6]  = '{32'hFE000CE3, SE12_BR,  64'hFFFF_FFFF_FFFF_FFF8, 1'b0};
        vecs[7]  = '{32'h000000E3, SE12_BR,  64'h0000_0000_0000_0800, 1'b0};
        vecs[8]  = '{32'h0010006F, SE20_JP,  64'h0000_0000_0000_0800, 1'b0};
        vecs[9]  = '{32'hFFFFF06F, SE20_JP,  64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
        vecs[10] = '{32'h0000106F, SE20_JP,  64'h0000_0000_0000_1000, 1'b0};
        vecs[11] = '{32'h340FD073, ZE05_CS,  64'h0000_0000_0000_001F, 1'b0};
        vecs[12] = '{32'h01F00013, SE05,     64'h0000_0000_0000_001F, 1'b0};
        vecs[13] = '{32'hFFFFFFFF, RSVD_101, 64'h0000_0000_0000_0000, 1'b1};
        vecs[14] = '{32'h7FF00013, ZE05_CS,  64'h0000_0000_0000_0000, 1'b0};

        idle();
        rst = 1'b1;
        flush = 1'b0;
        bus.OUT_READY = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(bus.OUT_VALID), 64'd0);
        chk("rst_in_ready", 64'(bus.IN_READY), 64'd1);
        chk("rst_out_imm", bus.OUT_IMM, 64'd0);
        chk("rst_out_tag", 64'(bus.OUT_TAG), 64'd0);
        chk("rst_out_ill", 64'(bus.OUT_ILLEGAL), 64'd0);
        chk("rst_ill_cnt", 64'(ill_cnt), 64'd0);
        rst = 1'b0;

        // Format table: one entry at a time, checked one cycle after accept.
        for (int i = 0; i < int'(NVEC); i++) begin
            @(negedge clk);
            drive(vecs[i].inst, vecs[i].sel, 32'hA000_0000 + 32'(i));
            chk("tbl_in_ready", 64'(bus.IN_READY), 64'd1);
            @(negedge clk);
            idle();
            if (vecs[i].ill) exp_ill++;
            chk($sformatf("tbl%0d_valid", i), 64'(bus.OUT_VALID), 64'd1);
            chk($sformatf("tbl%0d_imm", i), bus.OUT_IMM, vecs[i].imm);
            chk($sformatf("tbl%0d_ill", i), 64'(bus.OUT_ILLEGAL), 64'(vecs[i].ill));
            chk($sformatf("tbl%0d_tag", i), 64'(bus.OUT_TAG), 64'(32'hA000_0000 + 32'(i)));
        end
        @(negedge clk);
        chk("tbl_drained", 64'(bus.OUT_VALID), 64'd0);
        chk("tbl_ill_cnt", 64'(ill_cnt), 64'(exp_ill));

        // Three back-to-back entries against a stalled consumer, then drain.
        exp_imm[0] = 64'h7FF;      exp_tag[0] = 32'h1;
        exp_imm[1] = 64'h12345000; exp_tag[1] = 32'h2;
        exp_imm[2] = 64'h1F;       exp_tag[2] = 32'h3;
        bus.OUT_READY = 1'b0;
        drive(32'h7FF00013, SE12_LI, 32'h1);
        chk("stall_ready_a", 64'(bus.IN_READY), 64'd1);
        @(negedge clk);
        drive(32'h12345037, SE20_UI, 32'h2);
        chk("stall_valid_a", 64'(bus.OUT_VALID), 64'd1);
        chk("stall_imm_a", bus.OUT_IMM, exp_imm[0]);
        @(negedge clk);
        drive(32'h01F00013, SE05, 32'h3);
        chk("stall_full", 64'(bus.IN_READY), 64'd0);
        repeat (3) begin
            @(negedge clk);
            chk("stall_hold_valid", 64'(bus.OUT_VALID), 64'd1);
            chk("stall_hold_imm", bus.OUT_IMM, exp_imm[0]);
            chk("stall_hold_tag", 64'(bus.OUT_TAG), 64'(exp_tag[0]));
            chk("stall_hold_ready", 64'(bus.IN_READY), 64'd0);
        end
        bus.OUT_READY = 1'b1;
        got = 0;
        pend = 1'b0;
        for (int c = 0; c < 12 && got < 3; c++) begin
            if (bus.OUT_VALID && bus.OUT_READY) begin
                chk($sformatf("drain%0d_imm", got), bus.OUT_IMM, exp_imm[got]);
                chk($sformatf("drain%0d_tag", got), 64'(bus.OUT_TAG), 64'(exp_tag[got]));
                got++;
            end
            if (bus.IN_VALID && bus.IN_READY) pend = 1'b1;
            @(negedge clk);
            if (pend) begin
                idle();
                pend = 1'b0;
            end
        end
        chk("drain_count", 64'(got), 64'd3);
        chk("drain_empty", 64'(bus.OUT_VALID), 64'd0);
        idle();

        // Flush at count=2 with an offered entry.
        bus.OUT_READY = 1'b0;
        @(negedge clk);
        drive(32'h00000013, SE12_LI, 32'h10);
        @(negedge clk);
        drive(32'h7FF00013, SE12_LI, 32'h11);
        @(negedge clk);
        chk("fl2_full", 64'(bus.IN_READY), 64'd0);
        flush = 1'b1;
        drive(32'hFFFFFFFF, RSVD_101, 32'h12);
        @(negedge clk);
        flush = 1'b0;
        idle();
        chk("fl2_valid", 64'(bus.OUT_VALID), 64'd0);
        chk("fl2_ready", 64'(bus.IN_READY), 64'd1);
        chk("fl2_ill_cnt", 64'(ill_cnt), 64'(exp_ill));

        // Flush at count=1 while an illegal entry is accepted the same cycle.
        drive(32'h12345037, SE20_UI, 32'h13);
        @(negedge clk);
        flush = 1'b1;
        drive(32'hFFFFFFFF, RSVD_101, 32'h14);
        chk("fl1_ready", 64'(bus.IN_READY), 64'd1);
        @(negedge clk);
        flush = 1'b0;
        idle();
        chk("fl1_valid", 64'(bus.OUT_VALID), 64'd0);
        chk("fl1_ill_cnt", 64'(ill_cnt), 64'(exp_ill));
        @(negedge clk);
        chk("fl1_still_empty", 64'(bus.OUT_VALID), 64'd0);
        bus.OUT_READY = 1'b1;
        drive(32'h02109093, SE05, 32'h15);
        @(negedge clk);
        idle();
        chk("post_fl_imm", bus.OUT_IMM, 64'h21);
        chk("post_fl_tag", 64'(bus.OUT_TAG), 64'h15);
        @(negedge clk);
        chk("post_fl_empty", 64'(bus.OUT_VALID), 64'd0);

        // Saturation of the illegal counter under full-throughput streaming.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_ill = 0;
        chk("sat_start", 64'(ill_cnt), 64'd0);
        drive(32'hFFFFFFFF, RSVD_101, 32'h20);
        acc = 0;
        for (int c = 0; c < 400 && acc < 260; c++) begin
            if (bus.OUT_VALID) begin
                chk("sat_imm", bus.OUT_IMM, 64'd0);
                chk("sat_ill", 64'(bus.OUT_ILLEGAL), 64'd1);
            end
            took = bus.IN_VALID && bus.IN_READY;
            @(negedge clk);
            if (took) begin
                acc++;
                if (exp_ill < 255) exp_ill++;
            end
            if (acc == 260) idle();
            chk("sat_cnt", 64'(ill_cnt), 64'(exp_ill));
        end
        chk("sat_accepts", 64'(acc), 64'd260);
        chk("sat_final", 64'(ill_cnt), 64'd255);
        chk("sat_last_valid", 64'(bus.OUT_VALID), 64'd1);
        @(negedge clk);
        chk("sat_empty", 64'(bus.OUT_VALID), 64'd0);

        // Reset with two held entries beats flush and a concurrent offer.
        bus.OUT_READY = 1'b0;
        drive(32'hFFF00093, SE12_LI, 32'h30);
        @(negedge clk);
        drive(32'h800000B7, SE20_UI, 32'h31);
        @(negedge clk);
        chk("rst2_full", 64'(bus.IN_READY), 64'd0);
        chk("rst2_head", bus.OUT_IMM, 64'hFFFF_FFFF_FFFF_FFFF);
        rst = 1'b1;
        flush = 1'b1;
        drive(32'hFFFFFFFF, RSVD_101, 32'h32);
        @(negedge clk);
        rst = 1'b0;
        flush = 1'b0;
        idle();
        chk("rst2_valid", 64'(bus.OUT_VALID), 64'd0);
        chk("rst2_ill_cnt", 64'(ill_cnt), 64'd0);
        chk("rst2_imm", bus.OUT_IMM, 64'd0);
        chk("rst2_tag", 64'(bus.OUT_TAG), 64'd0);
        chk("rst2_ill", 64'(bus.OUT_ILLEGAL), 64'd0);
        chk("rst2_ready", 64'(bus.IN_READY), 64'd1);
        @(negedge clk);
        chk("rst2_stay_empty", 64'(bus.OUT_VALID), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
